sub32_pipe: RTL and testbench

SUB32_PIPE -- requirements
Module: sub32_pipe

---
 rtl/sub32_pkg.sv | 11 +
 rtl/sub32_pipe_sub_half.sv | 14 +
 rtl/sub32_pipe.sv | 64 ++++++
 tb/tb_sub32_pipe.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sub32_pkg.sv
// sub32_pkg: shared constants and the stage-1 record for sub32_pipe.
package sub32_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int HALF = DEF_WIDTH / 2;
  typedef struct packed {
    logic [HALF-1:0] d_lo;
    logic            b_lo;
    logic [HALF-1:0] x_hi;
    logic [HALF-1:0] y_hi;
  } s1_t;
endpackage

// File: rtl/sub32_pipe_sub_half.sv
// sub_half: combinational half-width subtractor with borrow in/out.
module sub_half
  import sub32_pkg::*;
#(
  parameter int N = HALF
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic [N-1:0] d,
  output logic         bout
);
  assign {bout, d} = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, bin};
endmodule

// File: rtl/sub32_pipe.sv
// sub32_pipe: two-stage valid/ready pipelined subtractor, low half in S1, high half in S2.
// Define SUB32_FLAGS_EN to add registered zero/ovf flag outputs.
module sub32_pipe
  import sub32_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SUB32_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);
  localparam int H = WIDTH / 2;
  s1_t s1;
  logic s1_valid, s2_adv, s1_adv, lo_b, hi_b;
  logic [H-1:0] lo_d, hi_d;
  assign s2_adv = !out_valid || out_ready;
  assign s1_adv = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  sub_half #(.N(H)) u_lo (.a(x[H-1:0]), .b(y[H-1:0]), .bin(bin), .d(lo_d), .bout(lo_b));
  sub_half #(.N(H)) u_hi (.a(s1.x_hi), .b(s1.y_hi), .bin(s1.b_lo), .d(hi_d), .bout(hi_b));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1        <= '0;
      out_valid <= 1'b0;
      diff      <= '0;
      borrow    <= 1'b0;
`ifdef SUB32_FLAGS_EN
      zero      <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) s1 <= '{d_lo: lo_d, b_lo: lo_b, x_hi: x[WIDTH-1:H], y_hi: y[WIDTH-1:H]};
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          diff   <= {hi_d, s1.d_lo};
          borrow <= hi_b;
`ifdef SUB32_FLAGS_EN
          zero   <= ({hi_d, s1.d_lo} == '0);
          // signed overflow: operand signs differ and result sign flips away from x
          ovf    <= (s1.x_hi[H-1] ^ s1.y_hi[H-1]) & (hi_d[H-1] ^ s1.x_hi[H-1]);
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_sub32_pipe.sv
// tb_sub32_pipe: randomized and directed self-checking bench for sub32_pipe against a queue model.
module tb_sub32_pipe;
  localparam int W = 32;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, bin = 0;
  logic [W-1:0] x = 0, y = 0;
  logic in_ready, out_valid, borrow;
  logic [W-1:0] diff;
`ifdef SUB32_FLAGS_EN
  logic zero, ovf;
`endif
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {
    logic [W-1:0] d;
    logic b;
    logic z;
    logic o;
    int acc;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  sub32_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow)
`ifdef SUB32_FLAGS_EN
    , .zero(zero), .ovf(ovf)
`endif
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic c, int acc);
    exp_t e;
    longint sa, sb, r;
    sa = $signed(a);
    sb = $signed(b);
    r = sa - sb - longint'(c);
    e.d = a - b - W'(c);
    e.b = ({32'b0, a} < ({32'b0, b} + 64'(c)));
    e.o = (r < -(longint'(1) <<< 31)) || (r > (longint'(1) <<< 31) - 1);
    e.z = (e.d == 0);
    e.acc = acc;
    return e;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          chk("diff", diff, q[0].d);
          chk("borrow", borrow, q[0].b);
`ifdef SUB32_FLAGS_EN
          chk("zero", zero, q[0].z);
          chk("ovf", ovf, q[0].o);
`endif
          chk("latency_age", (cyc - q[0].acc) >= 2, 1);
          if (out_ready) void'(q.pop_front());
        end
      end else if (q.size() > 0) chk("bubble_age", cyc - q[0].acc, 1);
      if (in_valid && in_ready) q.push_back(model(x, y, bin, cyc));
    end
  end

  task automatic drive(logic v, logic [W-1:0] a, logic [W-1:0] b, logic c, logic r);
    in_valid = v; x = a; y = b; bin = c; out_ready = r;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(6))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h0000_FFFF;
      4: return 32'h0001_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic direct(string n, logic [W-1:0] a, logic [W-1:0] b, logic c,
                        logic [W-1:0] ed, logic eb, logic ez, logic eo);
    drive(1, a, b, c, 1);
    step;
    drive(0, $urandom, $urandom, 1'($urandom), 1);
    step;
    @(negedge clk);
    chk({n, "_valid"}, out_valid, 1);
    chk({n, "_diff"}, diff, ed);
    chk({n, "_borrow"}, borrow, eb);
`ifdef SUB32_FLAGS_EN
    chk({n, "_zero"}, zero, ez);
    chk({n, "_ovf"}, ovf, eo);
`else
    if (ez === 1'bx || eo === 1'bx) $display("note: flag expectations undefined");
`endif
    step;
  endtask

  task automatic drain(string n);
    int t = 0;
    drive(0, 0, 0, 0, 1);
    while (q.size() > 0 && t < 20) begin
      step;
      t++;
    end
    step;
    chk({n, "_drained"}, q.size(), 0);
    chk({n, "_idle"}, out_valid, 0);
  endtask

  initial begin
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #2;
    rst_n = 1;
    step;
    direct("sub_5_3", 32'd5, 32'd3, 0, 32'd2, 0, 0, 0);
    direct("sub_0_1", 32'd0, 32'd1, 0, 32'hFFFF_FFFF, 1, 0, 0);
    direct("cross_half", 32'h0001_0000, 32'd1, 0, 32'h0000_FFFF, 0, 0, 0);
    direct("ovf_min", 32'h8000_0000, 32'd1, 0, 32'h7FFF_FFFF, 0, 0, 1);
    direct("zero_eq", 32'h1234, 32'h1234, 0, 32'd0, 0, 1, 0);
    direct("bin_only", 32'd0, 32'd0, 1, 32'hFFFF_FFFF, 1, 0, 0);
    direct("ones_bin", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1, 0, 0);
    direct("ovf_max", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 32'h8000_0000, 1, 0, 1);
    begin
      int k = 0, n = 0;
      logic saw = 0;
      while (n < 8 && k < 50) begin
        drive(1, $urandom, $urandom, 1'($urandom), !(k >= 3 && k < 6));
        @(negedge clk);
        if (!in_ready) saw = 1;
        else n++;
        step;
        k++;
      end
      chk("stream_in_ready_low", saw, 1);
      chk("stream_accepted", n, 8);
      drain("stream");
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, $urandom, $urandom, 1'($urandom), 0);
      step;
    end
    #2;
    rst_n = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_diff", diff, 0);
    chk("midrst_borrow", borrow, 0);
    chk("midrst_in_ready", in_ready, 1);
`ifdef SUB32_FLAGS_EN
    chk("midrst_zero", zero, 0);
    chk("midrst_ovf", ovf, 0);
`endif
    q.delete();
    step;
    step;
    #1;
    rst_n = 1;
    drive(1, 32'd9, 32'd4, 0, 1);
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
    step;
    drain("post_reset");
    for (int i = 0; i < 100; i++) begin
      drive(1, pick(), pick(), 1'($urandom), 1);
      step;
    end
    drain("full_rate");
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(3) != 0, pick(), pick(), 1'($urandom), $urandom_range(3) != 0);
      step;
    end
    drain("random");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
